phys_regfile: RTL
=================

PHYS_REGFILE -- requirements
Module: phys_regfile

Interface
REQ-001 SHALL have parameter NUM_PREGS, default 64, number of physical registers (power of two, >=8).
REQ-002 SHALL have parameter DATA_W, default 32, register data width.
REQ-003 SHALL have parameter NUM_RD, default 4, read channels (each reads rs1 and rs2).
REQ-004 SHALL have parameter NUM_WR, default 2, writeback channels.
REQ-005 SHALL have parameter NUM_ALLOC, default 2, rename-allocation channels.
REQ-006 SHALL have port clk  input  1  sole clock, all state on rising edge.
REQ-007 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-008 SHALL have port rd_req  input  NUM_RD x prfRdReqStruct  rs1/rs2 preg indices, log2(NUM_PREGS) bits each.
REQ-009 SHALL have port rd_resp  output  NUM_RD x prfRdRespStruct  rs1_data, rs2_data (DATA_W), rs1_rdy, rs2_rdy.
REQ-010 SHALL have port wr_req  input  NUM_WR x prfWrReqStruct  RegWrite, rd, wr_data.
REQ-011 SHALL have port alloc_req  input  NUM_ALLOC x prfAllocStruct  valid, preg being allocated to a new producer.
REQ-012 SHALL have port flush  input  1  pipeline squash, marks all pregs ready.
REQ-013 SHALL have port busy_cnt  output  log2(NUM_PREGS)+1  registered count of not-ready pregs.

Function
REQ-014 SHALL hold NUM_PREGS x DATA_W data words and one ready bit per preg.
REQ-015 Reads SHALL be combinational, zero latency.
REQ-016 Read of a preg written by any wr_req in the same cycle SHALL return that wr_data (write-through bypass) and rdy=1.
REQ-017 Otherwise read SHALL return stored data and stored ready bit.
REQ-018 Preg 0 SHALL always read data 0, rdy 1; writes and allocs to preg 0 SHALL be ignored, including for bypass.
REQ-019 Write with RegWrite=1 SHALL update data and set ready=1 on next edge.
REQ-020 Multiple wr channels to same rd in one cycle SHALL resolve highest channel index wins (data and bypass).
REQ-021 Valid alloc SHALL clear the preg's ready bit on next edge.
REQ-022 Alloc and write to same preg in same cycle: data SHALL be written, ready SHALL end 0 (alloc wins ready bit).
REQ-023 flush=1 SHALL set all ready bits to 1 on next edge; same-cycle writes SHALL still update data; same-cycle allocs SHALL be discarded.
REQ-024 busy_cnt SHALL equal the number of ready=0 pregs after the previous edge (registered popcount of next-state ready vector), range 0..NUM_PREGS-1.
REQ-025 Data SHALL never change except via wr_req or reset.

Reset
REQ-026 reset=1 at an edge SHALL set all data to 0, all ready bits to 1, busy_cnt to 0; reset SHALL override writes, allocs and flush in that cycle.
REQ-027 Combinational rd_resp during reset cycle SHALL still follow REQ-015..018 on current state.

Structure
REQ-028 prfRdReqStruct, prfRdRespStruct, prfWrReqStruct, prfAllocStruct and default NUM_PREGS/DATA_W constants SHALL live in package typedefs.
REQ-029 Ready bits, alloc/flush logic and busy_cnt SHALL be a sub-module prf_ready_table; data array and bypass stay in phys_regfile.
REQ-030 SHALL include assertions: preg 0 data always 0; no two alloc channels allocate same nonzero preg in one cycle.

Verification
REQ-031 Reset, then read pregs 0..63 -> all data 0, all rdy 1, busy_cnt 0.
REQ-032 Alloc preg 5 cycle N; read cycle N+1 -> rdy 0, busy_cnt 1; write 0xDEADBEEF to 5 cycle N+2 -> same-cycle read returns 0xDEADBEEF rdy 1; cycle N+3 busy_cnt 0.
REQ-033 wr ch0 rd=9 data 0x11, ch1 rd=9 data 0x22 same cycle -> same-cycle and later reads of 9 return 0x22.
REQ-034 Write rd=0 data 0xFFFFFFFF with alloc preg 0 -> reads of preg 0 return 0, rdy 1, busy_cnt unchanged.
REQ-035 Alloc pregs 3,4,7; then flush with write rd=3 data 0x55 and alloc preg 8 -> next cycle all rdy 1, preg 3 reads 0x55, busy_cnt 0.
REQ-036 Alloc preg 6 and write preg 6 data 0x77 same cycle -> next cycle reads 0x77, rdy 0, busy_cnt 1; assert reset mid-sequence -> all cleared next edge.

Source files
------------

// File: rtl/typedefs.sv
// Shared types and default sizing for the physical register file.
package typedefs;

    localparam int PRF_NUM_PREGS = 64;
    localparam int PRF_DATA_W    = 32;
    localparam int PRF_IDX_W     = $clog2(PRF_NUM_PREGS);

    typedef logic [PRF_IDX_W-1:0] preg_idx_t;

    typedef struct packed {
        preg_idx_t rs1;
        preg_idx_t rs2;
    } prfRdReqStruct;

    typedef struct packed {
        logic [PRF_DATA_W-1:0] rs1_data;
        logic [PRF_DATA_W-1:0] rs2_data;
        logic                  rs1_rdy;
        logic                  rs2_rdy;
    } prfRdRespStruct;

    typedef struct packed {
        logic                  RegWrite;
        preg_idx_t             rd;
        logic [PRF_DATA_W-1:0] wr_data;
    } prfWrReqStruct;

    typedef struct packed {
        logic      valid;
        preg_idx_t preg;
    } prfAllocStruct;

endpackage

// File: rtl/prf_ready_table.sv
// Ready-bit scoreboard: writes set ready, allocations clear it, flush sets
// everything ready. Also keeps a registered count of not-ready pregs.
module prf_ready_table
    import typedefs::*;
#(
    parameter int NUM_PREGS = PRF_NUM_PREGS,
    parameter int NUM_WR    = 2,
    parameter int NUM_ALLOC = 2
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [NUM_WR-1:0]            wr_en,
    input  preg_idx_t [NUM_WR-1:0]       wr_rd,
    input  prfAllocStruct [NUM_ALLOC-1:0] alloc_req,
    input  logic                         flush,
    output logic [NUM_PREGS-1:0]         ready,
    output logic [$clog2(NUM_PREGS):0]   busy_cnt
);

    localparam int CNT_W = $clog2(NUM_PREGS) + 1;

    logic [NUM_PREGS-1:0] ready_q;
    logic [NUM_PREGS-1:0] ready_nxt;
    logic [CNT_W-1:0]     busy_q;

    // Number of zero bits in a ready vector.
    function automatic logic [CNT_W-1:0] count_busy(input logic [NUM_PREGS-1:0] v);
        logic [CNT_W-1:0] cnt;
        cnt = '0;
        for (int i = 0; i < NUM_PREGS; i++) begin
            if (!v[i]) cnt = cnt + CNT_W'(1);
        end
        return cnt;
    endfunction

    // Next ready vector: writes first, then allocs so an alloc wins the bit;
    // flush drops allocs and marks everything ready. Preg 0 is pinned ready.
    always_comb begin
        ready_nxt = ready_q;
        for (int w = 0; w < NUM_WR; w++) begin
            if (wr_en[w]) ready_nxt[wr_rd[w]] = 1'b1;
        end
        if (flush) begin
            ready_nxt = '1;
        end else begin
            for (int a = 0; a < NUM_ALLOC; a++) begin
                if (alloc_req[a].valid) ready_nxt[alloc_req[a].preg] = 1'b0;
            end
        end
        ready_nxt[0] = 1'b1;
    end

    // Ready state and busy count register; reset overrides all updates.
    always_ff @(posedge clk) begin
        if (reset) begin
            ready_q <= '1;
            busy_q  <= '0;
        end else begin
            ready_q <= ready_nxt;
            busy_q  <= count_busy(ready_nxt);
        end
    end

    assign ready    = ready_q;
    assign busy_cnt = busy_q;

endmodule

// File: rtl/phys_regfile.sv
// Physical register file: data array with combinational, write-through
// reads; ready tracking lives in prf_ready_table.
module phys_regfile
    import typedefs::*;
#(
    parameter int NUM_PREGS = PRF_NUM_PREGS,
    parameter int DATA_W    = PRF_DATA_W,
    parameter int NUM_RD    = 4,
    parameter int NUM_WR    = 2,
    parameter int NUM_ALLOC = 2
) (
    input  logic                          clk,
    input  logic                          reset,
    input  prfRdReqStruct [NUM_RD-1:0]    rd_req,
    output prfRdRespStruct [NUM_RD-1:0]   rd_resp,
    input  prfWrReqStruct [NUM_WR-1:0]    wr_req,
    input  prfAllocStruct [NUM_ALLOC-1:0] alloc_req,
    input  logic                          flush,
    output logic [$clog2(NUM_PREGS):0]    busy_cnt
);

    // Struct fields are sized from the package defaults; DATA_W and
    // NUM_PREGS must agree with them.
    logic [DATA_W-1:0]    mem [NUM_PREGS];
    logic [NUM_PREGS-1:0] ready;
    logic [NUM_WR-1:0]    wr_en;
    preg_idx_t [NUM_WR-1:0] wr_rd;
    logic                 alloc_dup;

    // Read one preg: preg 0 is hardwired zero/ready; otherwise the
    // highest-indexed same-cycle writer bypasses the stored word.
    function automatic logic [DATA_W:0] read_port(
        input preg_idx_t                  idx,
        input logic [DATA_W-1:0]          stored_data,
        input logic                       stored_rdy,
        input prfWrReqStruct [NUM_WR-1:0] wr
    );
        logic [DATA_W-1:0] d;
        logic              r;
        d = stored_data;
        r = stored_rdy;
        for (int w = 0; w < NUM_WR; w++) begin
            if (wr[w].RegWrite && wr[w].rd == idx) begin
                d = wr[w].wr_data;
                r = 1'b1;
            end
        end
        if (idx == '0) begin
            d = '0;
            r = 1'b1;
        end
        return {r, d};
    endfunction

    // Qualified write enables; writes to preg 0 are dropped everywhere.
    always_comb begin
        wr_en = '0;
        wr_rd = '0;
        for (int w = 0; w < NUM_WR; w++) begin
            wr_en[w] = wr_req[w].RegWrite && (wr_req[w].rd != '0);
            wr_rd[w] = wr_req[w].rd;
        end
    end

    // Data array; later channels are applied last so the highest index wins.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NUM_PREGS; i++) mem[i] <= '0;
        end else begin
            for (int w = 0; w < NUM_WR; w++) begin
                if (wr_en[w]) mem[wr_req[w].rd] <= wr_req[w].wr_data;
            end
        end
    end

    // Combinational read ports, two operands per channel.
    always_comb begin
        logic [DATA_W:0] r1;
        logic [DATA_W:0] r2;
        rd_resp = '0;
        for (int r = 0; r < NUM_RD; r++) begin
            r1 = read_port(rd_req[r].rs1, mem[rd_req[r].rs1], ready[rd_req[r].rs1], wr_req);
            r2 = read_port(rd_req[r].rs2, mem[rd_req[r].rs2], ready[rd_req[r].rs2], wr_req);
            rd_resp[r].rs1_data = r1[DATA_W-1:0];
            rd_resp[r].rs1_rdy  = r1[DATA_W];
            rd_resp[r].rs2_data = r2[DATA_W-1:0];
            rd_resp[r].rs2_rdy  = r2[DATA_W];
        end
    end

    prf_ready_table #(
        .NUM_PREGS (NUM_PREGS),
        .NUM_WR    (NUM_WR),
        .NUM_ALLOC (NUM_ALLOC)
    ) u_ready (
        .clk       (clk),
        .reset     (reset),
        .wr_en     (wr_en),
        .wr_rd     (wr_rd),
        .alloc_req (alloc_req),
        .flush     (flush),
        .ready     (ready),
        .busy_cnt  (busy_cnt)
    );

    // Detect two alloc channels naming the same nonzero preg.
    always_comb begin
        alloc_dup = 1'b0;
        for (int i = 0; i < NUM_ALLOC; i++) begin
            for (int j = i + 1; j < NUM_ALLOC; j++) begin
                if (alloc_req[i].valid && alloc_req[j].valid &&
                    alloc_req[i].preg == alloc_req[j].preg &&
                    alloc_req[i].preg != '0)
                    alloc_dup = 1'b1;
            end
        end
    end

    a_preg0_zero: assert property (@(posedge clk) disable iff (reset) mem[0] == '0);
    a_alloc_uniq: assert property (@(posedge clk) disable iff (reset) !alloc_dup);

endmodule
